// File: rtl/sb_pkg.sv
// Shared constants and types for the GPR hazard scoreboard.
// Holds default sizing, the counter ceiling, event-type encodings and the
// per-entry event bundle handed from the decoder in the top to each entry.
package sb_pkg;

  localparam int unsigned SB_NUM_REGS = 32;
  localparam int unsigned SB_CNT_W    = 2;
  localparam int unsigned SB_CNT_MAX  = (1 << SB_CNT_W) - 1;
  localparam int unsigned SB_DEST_W   = 5;

  // Event kinds that can touch a scoreboard entry
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_ISSUE  = 2'd1,
    EV_LDRDY  = 2'd2,
    EV_RETIRE = 2'd3
  } sb_event_e;

  // Decoded per-register events for one cycle
  typedef struct packed {
    logic issue;
    logic issue_is_load;
    logic ldrdy;
    logic retire;
  } sb_evt_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: saturating in-flight writer counter plus the
// load-pending bit for a single architectural register.
// Ports:
//   clk, resetn      clock, async active-low reset
//   evt              decoded issue/ldrdy/retire events for this register
//   count            registered in-flight writer count
//   ld_pend          registered: youngest writer is a load whose data is not ready
//   ovf_c / unf_c    combinational pulses: issue at ceiling / retire at zero
module sb_entry
  import sb_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  sb_evt_t          evt,
  output logic [CNT_W-1:0] count,
  output logic             ld_pend,
  output logic             ovf_c,
  output logic             unf_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_nxt;
  logic             ld_pend_nxt;

  // Next-state: issue and retire together cancel; otherwise saturate/hold
  always_comb begin
    count_nxt   = count;
    ld_pend_nxt = ld_pend;
    ovf_c       = 1'b0;
    unf_c       = 1'b0;

    case ({evt.issue, evt.retire})
      2'b10: begin
        if (count == CNT_MAX) ovf_c = 1'b1;
        else                  count_nxt = count + CNT_W'(1);
      end
      2'b01: begin
        if (count == '0) unf_c = 1'b1;
        else             count_nxt = count - CNT_W'(1);
      end
      default: ;
    endcase

    // A new issue is always the youngest writer, so it wins over ldrdy
    if (evt.issue)
      ld_pend_nxt = evt.issue_is_load;
    else if (evt.ldrdy || (evt.retire && (count_nxt == '0)))
      ld_pend_nxt = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      ld_pend <= 1'b0;
    end else begin
      count   <= count_nxt;
      ld_pend <= ld_pend_nxt;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// GPR hazard scoreboard: tracks in-flight writers per register and flags
// load-use hazards for the instruction sitting in ID.
// Ports:
//   clk, resetn                           clock, async active-low reset
//   issue_valid/issue_dest/issue_is_load  writer leaving ID
//   ldrdy_valid/ldrdy_dest                load data forwardable from MEM
//   retire_valid/retire_dest              regfile write committed in WB
//   rs1/rs1_en/rs2/rs2_en                 ID source operands
//   stall                                 combinational load-use hazard
//   busy_vec                              per-register count != 0
//   idle                                  no writer in flight anywhere
//   err_ovf/err_unf                       sticky counter overflow/underflow
// Build option: define HAZARD_SCOREBOARD_ERR_CHECK_EN to enable the error
// flags; without it they stay 0 while counters still saturate/hold.
module hazard_scoreboard
  import sb_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_NUM_REGS,
  parameter int unsigned CNT_W    = SB_CNT_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                issue_valid,
  input  logic [4:0]          issue_dest,
  input  logic                issue_is_load,
  input  logic                ldrdy_valid,
  input  logic [4:0]          ldrdy_dest,
  input  logic                retire_valid,
  input  logic [4:0]          retire_dest,
  input  logic [4:0]          rs1,
  input  logic                rs1_en,
  input  logic [4:0]          rs2,
  input  logic                rs2_en,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                idle,
  output logic                err_ovf,
  output logic                err_unf
);

  localparam int unsigned IDX_W    = SB_DEST_W;
  localparam int unsigned IDX_SPAN = 1 << IDX_W;

`ifdef HAZARD_SCOREBOARD_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [CNT_W-1:0]    count [NUM_REGS];
  logic [NUM_REGS-1:0] ld_pend;
  logic [NUM_REGS-1:0] ovf_vec;
  logic [NUM_REGS-1:0] unf_vec;
  logic [IDX_SPAN-1:0] ld_pend_ext;

  // Register 0 is hardwired: never busy, never pending
  assign count[0]   = '0;
  assign ld_pend[0] = 1'b0;
  assign ovf_vec[0] = 1'b0;
  assign unf_vec[0] = 1'b0;

  // One entry per tracked register; dest decode lives here
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    sb_evt_t evt;

    assign evt.issue         = issue_valid  && (issue_dest  == IDX_W'(i));
    assign evt.issue_is_load = issue_is_load;
    assign evt.ldrdy         = ldrdy_valid  && (ldrdy_dest  == IDX_W'(i));
    assign evt.retire        = retire_valid && (retire_dest == IDX_W'(i));

    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk     (clk),
      .resetn  (resetn),
      .evt     (evt),
      .count   (count[i]),
      .ld_pend (ld_pend[i]),
      .ovf_c   (ovf_vec[i]),
      .unf_c   (unf_vec[i])
    );
  end

  // Occupancy view of the counters
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = |count[i];
    end
  end

  assign idle = ~|busy_vec;

  // Widen so any 5-bit source index is in range
  assign ld_pend_ext = IDX_SPAN'(ld_pend);

  // Load-use hazard from registered state only, zero-cycle
  assign stall = (rs1_en && (rs1 != '0) && ld_pend_ext[rs1]) ||
                 (rs2_en && (rs2 != '0) && ld_pend_ext[rs2]);

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (ERR_EN && |ovf_vec) err_ovf <= 1'b1;
      if (ERR_EN && |unf_vec) err_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_is_load;
  logic        ldrdy_valid;
  logic [4:0]  ldrdy_dest;
  logic        retire_valid;
  logic [4:0]  retire_dest;
  logic [4:0]  rs1;
  logic        rs1_en;
  logic [4:0]  rs2;
  logic        rs2_en;
  logic        stall;
  logic [31:0] busy_vec;
  logic        idle;
  logic        err_ovf;
  logic        err_unf;

  hazard_scoreboard dut (
    .clk           (clk),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_dest    (issue_dest),
    .issue_is_load (issue_is_load),
    .ldrdy_valid   (ldrdy_valid),
    .ldrdy_dest    (ldrdy_dest),
    .retire_valid  (retire_valid),
    .retire_dest   (retire_dest),
    .rs1           (rs1),
    .rs1_en        (rs1_en),
    .rs2           (rs2),
    .rs2_en        (rs2_en),
    .stall         (stall),
    .busy_vec      (busy_vec),
    .idle          (idle),
    .err_ovf       (err_ovf),
    .err_unf       (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // e_stall is checked before the edge; the rest after it
  typedef struct {
    logic        iv;
    logic [4:0]  id;
    logic        il;
    logic        lv;
    logic [4:0]  ld;
    logic        rv;
    logic [4:0]  rd;
    logic [4:0]  r1;
    logic        r1e;
    logic [4:0]  r2;
    logic        r2e;
    logic        e_stall;
    logic [31:0] e_busy;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] b(input int n);
    return 32'(1) << n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int iv, input int id, input int il, input int lv, input int ld,
                     input int rv, input int rd, input int r1v, input int r1e, input int r2v,
                     input int r2e, input int es, input logic [31:0] eb, input int eo,
                     input int eu);
    vec_t v;
    v.iv = 1'(iv); v.id = 5'(id); v.il = 1'(il);
    v.lv = 1'(lv); v.ld = 5'(ld);
    v.rv = 1'(rv); v.rd = 5'(rd);
    v.r1 = 5'(r1v); v.r1e = 1'(r1e); v.r2 = 5'(r2v); v.r2e = 1'(r2e);
    v.e_stall = 1'(es); v.e_busy = eb; v.e_ovf = 1'(eo); v.e_unf = 1'(eu);
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_dest = v.id; issue_is_load = v.il;
    ldrdy_valid = v.lv; ldrdy_dest = v.ld;
    retire_valid = v.rv; retire_dest = v.rd;
    rs1 = v.r1; rs1_en = v.r1e; rs2 = v.r2; rs2_en = v.r2e;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_dest = 0; issue_is_load = 0;
    ldrdy_valid = 0; ldrdy_dest = 0;
    retire_valid = 0; retire_dest = 0;
    rs1 = 0; rs1_en = 0; rs2 = 0; rs2_en = 0;
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] eb, input logic eo,
                             input logic eu);
    chk({tag, ".busy_vec"}, busy_vec, eb);
    chk({tag, ".idle"}, 32'(idle), 32'(eb == 32'd0));
    chk({tag, ".err_ovf"}, 32'(err_ovf), 32'(eo & ERR_EN));
    chk({tag, ".err_unf"}, 32'(err_unf), 32'(eu & ERR_EN));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stall", 32'(stall), 32'd0);
    chk_outputs("reset", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    //   iv id il  lv ld  rv rd  r1 e  r2 e  stall busy  ovf unf
    add(1, 5, 1,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(5), 0, 0);  // load -> r5
    add(0, 0, 0,  0, 0,  0, 0,  5, 1, 0, 0,  1, b(5), 0, 0);  // use r5: stall
    add(0, 0, 0,  1, 5,  0, 0,  5, 1, 0, 0,  1, b(5), 0, 0);  // ldrdy r5, still stall this cycle
    add(0, 0, 0,  0, 0,  0, 0,  5, 1, 0, 0,  0, b(5), 0, 0);  // released, still busy
    add(0, 0, 0,  0, 0,  1, 5,  5, 1, 0, 0,  0, 32'd0, 0, 0); // retire r5
    add(1, 7, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(7), 0, 0);  // add -> r7
    add(0, 0, 0,  0, 0,  0, 0,  0, 0, 7, 1,  0, b(7), 0, 0);  // rs2=r7: no stall
    add(0, 0, 0,  0, 0,  1, 7,  0, 0, 0, 0,  0, 32'd0, 0, 0);
    add(1, 3, 1,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(3), 0, 0);  // load -> r3
    add(1, 3, 0,  0, 0,  0, 0,  3, 1, 0, 0,  1, b(3), 0, 0);  // add -> r3 clears pend
    add(0, 0, 0,  0, 0,  0, 0,  3, 1, 0, 0,  0, b(3), 0, 0);
    add(0, 0, 0,  0, 0,  1, 3,  0, 0, 0, 0,  0, b(3), 0, 0);  // count 2 -> 1
    add(0, 0, 0,  0, 0,  1, 3,  0, 0, 0, 0,  0, 32'd0, 0, 0); // count 1 -> 0
    add(1, 9, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(9), 0, 0);
    add(1, 9, 0,  0, 0,  1, 9,  0, 0, 0, 0,  0, b(9), 0, 0);  // issue+retire: stays 1
    add(0, 0, 0,  0, 0,  1, 9,  0, 0, 0, 0,  0, 32'd0, 0, 0); // one retire empties it
    add(1, 9, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(9), 0, 0);
    add(1, 9, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(9), 0, 0);
    add(1, 9, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(9), 0, 0);  // count 3
    add(1, 9, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, b(9), 1, 0);  // 4th: saturate + ovf
    add(0, 0, 0,  0, 0,  1, 9,  0, 0, 0, 0,  0, b(9), 1, 0);
    add(0, 0, 0,  0, 0,  1, 9,  0, 0, 0, 0,  0, b(9), 1, 0);
    add(0, 0, 0,  0, 0,  1, 9,  0, 0, 0, 0,  0, 32'd0, 1, 0); // three retires from 3
    add(1, 0, 0,  0, 0,  0, 0,  0, 1, 0, 0,  0, 32'd0, 1, 0); // dest 0 ignored
    add(0, 0, 0,  0, 0,  1, 0,  0, 0, 0, 0,  0, 32'd0, 1, 0); // retire r0: no unf
    add(1, 0, 1,  0, 0,  0, 0,  0, 1, 0, 0,  0, 32'd0, 1, 0); // load -> r0 ignored
    add(0, 0, 0,  0, 0,  0, 0,  0, 1, 0, 1,  0, 32'd0, 1, 0);
    add(1, 6, 1,  1, 6,  0, 0,  0, 0, 0, 0,  0, b(6), 1, 0);  // load issue + ldrdy same reg
    add(0, 0, 0,  0, 0,  0, 0,  0, 0, 6, 1,  1, b(6), 1, 0);  // new load still pending
    add(0, 0, 0,  0, 0,  0, 0,  6, 0, 6, 0,  0, b(6), 1, 0);  // enables low: no stall
    add(0, 0, 0,  0, 0,  1, 6,  0, 0, 6, 1,  1, 32'd0, 1, 0); // retire to 0 clears pend
    add(0, 0, 0,  0, 0,  0, 0,  0, 0, 6, 1,  0, 32'd0, 1, 0);
    add(0, 0, 0,  0, 0,  1, 4,  0, 0, 0, 0,  0, 32'd0, 1, 1); // retire at 0: unf
    add(1, 8, 1,  0, 0,  0, 0,  8, 1, 0, 0,  0, b(8), 1, 1);  // not visible same cycle
    add(0, 0, 0,  1, 2,  0, 0,  8, 1, 0, 0,  1, b(8), 1, 1);  // ldrdy elsewhere
    add(0, 0, 0,  0, 0,  0, 0,  8, 1, 0, 0,  1, b(8), 1, 1);  // r8 stays pending

    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      drive(vecs[k]);
      #1;
      chk({tag, ".stall"}, 32'(stall), 32'(vecs[k].e_stall));
      @(posedge clk);
      #1;
      chk_outputs(tag, vecs[k].e_busy, vecs[k].e_ovf, vecs[k].e_unf);
    end

    // Async reset mid-stream with loads pending on r8, r10, r11
    clear_inputs();
    issue_valid = 1; issue_dest = 5'd10; issue_is_load = 1;
    @(posedge clk); #1;
    issue_dest = 5'd11;
    @(posedge clk); #1;
    clear_inputs();
    rs1 = 5'd10; rs1_en = 1; rs2 = 5'd11; rs2_en = 1;
    #1;
    chk("pre_rst.stall", 32'(stall), 32'd1);
    chk_outputs("pre_rst", b(8) | b(10) | b(11), 1'b1, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst.stall", 32'(stall), 32'd0);
    chk_outputs("async_rst", 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.stall", 32'(stall), 32'd0);
    chk_outputs("post_rst", 32'd0, 1'b0, 1'b0);

    // Tracking resumes after reset
    clear_inputs();
    issue_valid = 1; issue_dest = 5'd12; issue_is_load = 1;
    @(posedge clk); #1;
    clear_inputs();
    rs2 = 5'd12; rs2_en = 1;
    #1;
    chk("resume.stall", 32'(stall), 32'd1);
    chk_outputs("resume", b(12), 1'b0, 1'b0);
    retire_valid = 1; retire_dest = 5'd12;
    @(posedge clk); #1;
    clear_inputs();
    chk_outputs("resume_retire", 32'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
